// File: rtl/sram_rd_port_ctrl_if.sv
// Client-side bundle for sram_rd_port_ctrl: write port, read request/response streams and flush.
// The master drives requests; the slave (the controller) answers them.
interface sram_rd_port_ctrl_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  flush;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;

    modport master (
        output flush,
        output wr_en,
        output wr_addr,
        output wr_data,
        output req_valid,
        input  req_ready,
        output req_addr,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data
    );

    modport slave (
        input  flush,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  req_valid,
        output req_ready,
        input  req_addr,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data
    );
endinterface

// File: rtl/sram_rd_port_ctrl.sv
// Valid/ready read front end for a 1R1W SRAM with a fixed, unstallable 2-cycle read.
// Tracks in-flight reads, forwards same-cycle writes and buffers returns against backpressure.
module sram_rd_port_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_rd_port_ctrl_if.slave    bus_io,
    output logic                  ram_wen_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [WIDTH-1:0]      ram_wdata_o,
    output logic                  ram_ren_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [WIDTH-1:0]      ram_rdata_i
);

    localparam int unsigned OccW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(RSP_DEPTH);
    localparam logic [OccW-1:0] OccMax  = OccW'(RSP_DEPTH);
    localparam logic [OccW-1:0] OccOne  = OccW'(1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(RSP_DEPTH - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    // Read tracking pipeline, aligned with the wrapper's two read stages
    logic             s1_vld_q, s1_fwd_q;
    logic [WIDTH-1:0] s1_fwd_data_q;
    logic             s2_vld_q, s2_fwd_q;
    logic [WIDTH-1:0] s2_fwd_data_q;

    logic [OccW-1:0]  occ_q, occ_d;
    logic [OccW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] fifo_mem_q [RSP_DEPTH];

    logic             req_ready, req_fire;
    logic             rsp_valid, rsp_fire;
    logic [WIDTH-1:0] rsp_data, ret_word;
    logic             fwd, fifo_empty, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrOne;
    endfunction

    // Write path is a pure passthrough
    assign ram_wen_o   = bus_io.wr_en & ~rst;
    assign ram_waddr_o = bus_io.wr_addr;
    assign ram_wdata_o = bus_io.wr_data;

    assign fifo_empty = (cnt_q == '0);
    assign ret_word   = s2_fwd_q ? s2_fwd_data_q : ram_rdata_i;

    assign rsp_valid = ~bus_io.flush & (~fifo_empty | s2_vld_q);
    assign rsp_data  = fifo_empty ? ret_word : fifo_mem_q[rd_ptr_q];
    assign rsp_fire  = rsp_valid & bus_io.rsp_ready;

    // A slot is freed in the same cycle a response leaves, so full occupancy does not stall
    assign req_ready = ~rst & ~bus_io.flush & ((occ_q < OccMax) | rsp_fire);
    assign req_fire  = bus_io.req_valid & req_ready;
    assign fwd       = bus_io.wr_en & (bus_io.wr_addr == bus_io.req_addr);

    assign push = s2_vld_q & ~bus_io.flush & ~(fifo_empty & bus_io.rsp_ready);
    assign pop  = ~fifo_empty & bus_io.rsp_ready & ~bus_io.flush;

    assign ram_ren_o   = req_fire;
    assign ram_raddr_o = bus_io.req_addr;

    assign bus_io.req_ready = req_ready;
    assign bus_io.rsp_valid = rsp_valid;
    assign bus_io.rsp_data  = rsp_data;

    always_comb begin
        occ_d = occ_q;
        unique case ({req_fire, rsp_fire})
            2'b10:   occ_d = occ_q + OccOne;
            2'b01:   occ_d = occ_q - OccOne;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + OccOne;
            2'b01:   cnt_d = cnt_q - OccOne;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q      <= 1'b0;
            s1_fwd_q      <= 1'b0;
            s1_fwd_data_q <= '0;
            s2_vld_q      <= 1'b0;
            s2_fwd_q      <= 1'b0;
            s2_fwd_data_q <= '0;
            occ_q         <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (bus_io.flush) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            s1_vld_q      <= req_fire;
            s1_fwd_q      <= fwd;
            s1_fwd_data_q <= bus_io.wr_data;
            s2_vld_q      <= s1_vld_q;
            s2_fwd_q      <= s1_fwd_q;
            s2_fwd_data_q <= s1_fwd_data_q;
            occ_q         <= occ_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only entries below cnt_q are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ret_word;
        end
    end

    // Occupancy accounting guarantees a push never lands on a full, non-popping buffer
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && (cnt_q == OccMax)));

endmodule

// File: tb/tb_sram_rd_port_ctrl.sv
// Directed self-checking bench for sram_rd_port_ctrl with a behavioural 2-cycle 1R1W RAM.
module tb_sram_rd_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_wen, ram_ren;
    logic [5:0]  ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata;

    int n_checks;
    int n_fail;
    int accepted;

    logic [31:0] ref_mem [64];

    // Wrapper model: address latched at the fire edge (old data), data out two cycles later
    logic [31:0] ram [64];
    logic [31:0] p1, p2;

    sram_rd_port_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(6)) bus ();

    sram_rd_port_ctrl #(
        .WIDTH     (32),
        .DEPTH     (64),
        .ADDR_WIDTH(6),
        .RSP_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_io     (bus),
        .ram_wen_o  (ram_wen),
        .ram_waddr_o(ram_waddr),
        .ram_wdata_o(ram_wdata),
        .ram_ren_o  (ram_ren),
        .ram_raddr_o(ram_raddr),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ren) p1 <= ram[ram_raddr];
        p2 <= p1;
        if (ram_wen) ram[ram_waddr] <= ram_wdata;
    end
    assign ram_rdata = p2;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(addr);
        bus.wr_data = data;
        ref_mem[addr] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b1;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #3;
        chk_b("rst_req_ready", bus.req_ready, 1'b0);
        chk_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk_b("rst_ram_ren", ram_ren, 1'b0);
        chk_b("rst_ram_wen", ram_wen, 1'b0);
        bus.wr_en     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_b("post_rst_req_ready", bus.req_ready, 1'b1);

        // Preload the RAM through the write passthrough
        for (int i = 0; i < 64; i++) begin
            do_write(i, 32'hC000_0000 + 32'(i));
            if (i == 3) begin
                #1;
                chk_b("wr_pass_en", ram_wen, 1'b1);
                chk_w("wr_pass_addr", 32'(ram_waddr), 32'd3);
                chk_w("wr_pass_data", ram_wdata, 32'hC000_0003);
            end
        end
        @(negedge clk);
        bus.wr_en = 1'b0;

        // 1: write then read, latency 2
        do_write(5, 32'hA5A5_0001);
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd5;
        bus.rsp_ready = 1'b1;
        #1;
        chk_b("t1_req_ready", bus.req_ready, 1'b1);
        chk_b("t1_ram_ren", ram_ren, 1'b1);
        chk_w("t1_ram_raddr", 32'(ram_raddr), 32'd5);
        chk_b("t1_rsp_valid_t0", bus.rsp_valid, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk_b("t1_rsp_valid_t1", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_b("t1_rsp_valid_t2", bus.rsp_valid, 1'b1);
        chk_w("t1_rsp_data", bus.rsp_data, 32'hA5A5_0001);
        @(negedge clk);
        #1;
        chk_b("t1_rsp_valid_t3", bus.rsp_valid, 1'b0);

        // 2: same-cycle collision forwards; a write one cycle later does not
        do_write(9, 32'h0000_FFFF);
        @(negedge clk);
        bus.wr_en = 1'b0;
        do_write(9, 32'h0000_1234);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd9;
        @(negedge clk);
        bus.wr_en     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk_b("t2_fwd_valid", bus.rsp_valid, 1'b1);
        chk_w("t2_fwd_data", bus.rsp_data, 32'h0000_1234);
        do_write(9, 32'h0000_FFFF);
        @(negedge clk);
        bus.wr_en     = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd9;
        do_write(9, 32'h0000_5555);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        #1;
        chk_b("t2_old_valid", bus.rsp_valid, 1'b1);
        chk_w("t2_old_data", bus.rsp_data, 32'h0000_FFFF);
        @(negedge clk);
        #1;
        chk_b("t2_idle", bus.rsp_valid, 1'b0);

        // 3: back-to-back reads at full rate
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k < 16) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 6'(k);
            end else begin
                bus.req_valid = 1'b0;
            end
            #1;
            if (k < 16) chk_b("t3_req_ready", bus.req_ready, 1'b1);
            if (k >= 2) begin
                chk_b("t3_rsp_valid", bus.rsp_valid, 1'b1);
                chk_w("t3_rsp_data", bus.rsp_data, ref_mem[k-2]);
            end
        end
        @(negedge clk);
        #1;
        chk_b("t3_idle", bus.rsp_valid, 1'b0);

        // 4: backpressure fills to RSP_DEPTH, then drain with concurrent new reads
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 6'(20 + accepted);
            #1;
            chk_b("t4_req_ready", bus.req_ready, (k < 4));
            if (bus.req_ready) accepted++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk_w("t4_accepted", 32'(accepted), 32'd4);
        repeat (3) @(negedge clk);
        #1;
        chk_b("t4_stall_valid", bus.rsp_valid, 1'b1);
        chk_w("t4_stall_head", bus.rsp_data, ref_mem[20]);
        chk_b("t4_stall_ready", bus.req_ready, 1'b0);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            if (j < 4) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 6'(30 + j);
            end else begin
                bus.req_valid = 1'b0;
            end
            #1;
            if (j < 4) chk_b("t4_drain_req_ready", bus.req_ready, 1'b1);
            if (j < 8) begin
                chk_b("t4_drain_valid", bus.rsp_valid, 1'b1);
                chk_w("t4_drain_data", bus.rsp_data, ref_mem[(j < 4) ? 20 + j : 26 + j]);
            end else begin
                chk_b("t4_drain_idle", bus.rsp_valid, 1'b0);
            end
        end

        // 5: flush with two reads in flight and one buffered
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 6'(10 + k);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 6'd40;
        bus.wr_data   = 32'hDEAD_0040;
        ref_mem[40]   = 32'hDEAD_0040;
        #1;
        chk_b("t5_flush_rsp_valid", bus.rsp_valid, 1'b0);
        chk_b("t5_flush_req_ready", bus.req_ready, 1'b0);
        chk_b("t5_flush_wr", ram_wen, 1'b1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        chk_b("t5_post_rsp_valid", bus.rsp_valid, 1'b0);
        chk_b("t5_post_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd40;
        bus.rsp_ready = 1'b1;
        #1;
        chk_b("t5_rd_rsp_valid_t0", bus.rsp_valid, 1'b0);
        chk_b("t5_rd_ren", ram_ren, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk_b("t5_rd_rsp_valid_t1", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_b("t5_rd_rsp_valid_t2", bus.rsp_valid, 1'b1);
        chk_w("t5_rd_data", bus.rsp_data, 32'hDEAD_0040);
        @(negedge clk);
        #1;
        chk_b("t5_rd_idle", bus.rsp_valid, 1'b0);
        // Occupancy must be zero again: exactly RSP_DEPTH reads accepted under backpressure
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 6'(50 + ((k < 4) ? k : 3));
            #1;
            chk_b("t5_occ_req_ready", bus.req_ready, (k < 4));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            #1;
            if (j < 4) begin
                chk_b("t5_occ_drain_valid", bus.rsp_valid, 1'b1);
                chk_w("t5_occ_drain_data", bus.rsp_data, ref_mem[50 + j]);
            end else begin
                chk_b("t5_occ_drain_idle", bus.rsp_valid, 1'b0);
            end
        end

        // 6: reset mid-stream
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 6'(1 + k);
        end
        #1;
        chk_b("t6_pre_valid", bus.rsp_valid, 1'b1);
        chk_w("t6_pre_data", bus.rsp_data, ref_mem[1]);
        #1;
        rst = 1'b1;
        #1;
        chk_b("t6_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk_b("t6_rst_ram_ren", ram_ren, 1'b0);
        chk_b("t6_rst_req_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk_b("t6_rel_req_ready", bus.req_ready, 1'b1);
        chk_b("t6_rel_rsp_valid", bus.rsp_valid, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk_b("t6_quiet", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd7;
        #1;
        chk_b("t6_new_ren", ram_ren, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk_b("t6_new_t1", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_b("t6_new_valid", bus.rsp_valid, 1'b1);
        chk_w("t6_new_data", bus.rsp_data, ref_mem[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
